aes_kat_sequencer: RTL and testbench
====================================

// Module: aes_kat_sequencer
// PURPOSE
//  On-chip known-answer-test (KAT) initiator for the AES core. It drives the core's control and data inputs and collects data_out/aes_done.
//  It runs FIPS-197 vectors in both modes, compares each result against the expected value and reports pass/fail.
//  Sits beside the AES instance as its stimulus/response end; used for power-on self-test and board bring-up.
// PARAMETERS
//  RST_CYCLES   4       cycles aes_reset is held high with inputs stable before each test (>=1)
//  TIMEOUT      1024    max cycles in RUN waiting for aes_done before the test is declared failed
//  N_ROUNDTRIP  8       LFSR round-trip pairs, used only with AES_KAT_ROUNDTRIP_EN
//  LFSR_SEED    128'h1  nonzero seed for the 128-bit round-trip LFSR
// PORTS
//  clk          in   1    single clock, all logic rising-edge
//  reset        in   1    synchronous, active-high
//  start        in   1    one-cycle pulse: begin the test sequence (ignored while busy)
//  aes_reset    out  1    to the core's reset; the core computes while this is low
//  aes_mode     out  1    to the core's mode; 0=encrypt, 1=decrypt
//  aes_data_in  out  128  to the core's data_in
//  aes_key_in   out  128  to the core's key_in
//  aes_data_out in   128  from the core's data_out
//  aes_done     in   1    from the core; level, high when data_out is valid
//  busy         out  1    sequence in progress
//  done         out  1    sequence finished; held until next start or reset
//  pass         out  1    done && err_count==0
//  fail         out  1    done && err_count!=0
//  err_count    out  8    number of failed tests (saturates at 255)
//  first_fail   out  8    index of first failing test; 8'hFF if none
// BEHAVIOUR
//  Reset values: aes_reset=1, aes_mode=0, aes_data_in=0, aes_key_in=0; busy=done=pass=fail=0, err_count=0, first_fail=8'hFF.
//  Fixed vector ROM (idx: mode, data_in, key, expected):
//   0: enc 3243f6a8885a308d313198a2e0370734 k 2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32
//   1: dec 3925841d02dc09fbdc118597196a0b32 same key -> 3243f6a8885a308d313198a2e0370734
//   2: enc 00112233445566778899aabbccddeeff k 000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a
//   3: dec 69c4e0d86a7b0430d8cdb78070b4c55a same key -> 00112233445566778899aabbccddeeff
//  FSM: IDLE -> LOAD -> RUN -> CHECK -> (LOAD of next test | DONE); DONE -> LOAD on start.
//   IDLE/DONE: aes_reset=1. start -> LOAD idx=0; clears done/pass/fail/err_count, sets first_fail=8'hFF, busy=1.
//   LOAD: aes_reset=1, mode/data/key driven from the test entry, held stable; after exactly RST_CYCLES cycles -> RUN.
//   RUN: aes_reset=0; inputs remain stable. aes_done is sampled only in RUN, from the 2nd RUN cycle onward.
//        On first aes_done=1, capture aes_data_out -> CHECK. If TIMEOUT cycles elapse without it, mark failed -> CHECK.
//   CHECK (1 cycle): mismatch or timeout -> err_count+1 (saturating); first_fail=idx if still FF.
//        Then last test -> DONE (busy=0, done=1, pass/fail set same edge) else idx+1 -> LOAD.
//  aes_reset returns high in the cycle after capture, so each test starts from a fresh core reset.
//  start while busy: ignored. start in DONE: restarts the full sequence.
//  reset mid-operation (any state): next edge all outputs take their reset values, FSM -> IDLE; no partial result kept.
//  Latency per passing test = RST_CYCLES + core latency + 2 cycles.
// CONFIGURATION
//  AES_KAT_ROUNDTRIP_EN defined:
//   - After test 3, N_ROUNDTRIP pairs run using key 2b7e151628aed2a6abf7158809cf4f3c.
//   - Pair j: encrypt P = LFSR state (Galois, taps 128,127,126,121; advanced once per pair).
//   - Then decrypt the captured ciphertext; expected = P. Test idx = 4+2j (enc, unchecked) and 5+2j (dec, checked).
//   - A timeout fails either half; a timed-out encrypt still runs its decrypt.
//  Not defined: exactly 4 tests; LFSR and round-trip logic absent.
// TESTING
//  T1 real AES core, start pulse -> 4 tests, done=1, pass=1, fail=0, err_count=0, first_fail=FF, busy low after.
//  T2 stub core returning expected^1 on idx 1 only -> done, fail=1, err_count=1, first_fail=1.
//  T3 stub never raising aes_done, TIMEOUT=16 -> each RUN lasts 16 cycles; done, err_count=4, first_fail=0.
//  T4 reset asserted for 1 cycle during RUN of idx 2 -> next cycle aes_reset=1, busy=0, err_count=0, first_fail=FF; a later start reruns from idx 0.
//  T5 start pulsed in LOAD and RUN -> no effect on idx/counts; start after done -> counts cleared, sequence repeats with same result.
//  T6 AES_KAT_ROUNDTRIP_EN, N_ROUNDTRIP=2, real core -> 8 tests, pass=1; stub corrupting idx 5 -> err_count=1, first_fail=5.

Source files
------------

// File: rtl/aes_kat_sequencer.sv
// aes_kat_sequencer: on-chip known-answer-test initiator for an AES core.
// It runs a fixed set of FIPS-197 vectors (encrypt and decrypt) through
// the core. Each test starts from a fresh core reset. The captured
// data_out is compared against the expected value, and the overall
// pass/fail result is reported.
//
// Optional feature: define AES_KAT_ROUNDTRIP_EN to append N_ROUNDTRIP
// LFSR-driven encrypt/decrypt round-trip pairs after the fixed vectors.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start         one-cycle pulse that begins the sequence (ignored while busy)
//   aes_reset     core reset (the core computes while this is low)
//   aes_mode      core mode, 0=encrypt 1=decrypt
//   aes_data_in   core plaintext/ciphertext input
//   aes_key_in    core key input
//   aes_data_out  core result
//   aes_done      core result-valid level
//   busy          sequence in progress
//   done          sequence finished (held until next start or reset)
//   pass / fail   done with zero / nonzero failures
//   err_count     failed test count, saturating at 255
//   first_fail    index of the first failing test, 8'hFF if none
module aes_kat_sequencer #(
    parameter int unsigned  RST_CYCLES  = 4,
    parameter int unsigned  TIMEOUT     = 1024,
    parameter int unsigned  N_ROUNDTRIP = 8,
    parameter logic [127:0] LFSR_SEED   = 128'h1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         aes_reset,
    output logic         aes_mode,
    output logic [127:0] aes_data_in,
    output logic [127:0] aes_key_in,
    input  logic [127:0] aes_data_out,
    input  logic         aes_done,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         fail,
    output logic [7:0]   err_count,
    output logic [7:0]   first_fail
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CHECK, S_DONE} state_t;

`ifdef AES_KAT_ROUNDTRIP_EN
    localparam int unsigned N_PAIRS = N_ROUNDTRIP;
`else
    localparam int unsigned N_PAIRS = 0;
`endif
    localparam int unsigned N_TESTS = 4 + 2 * N_PAIRS;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    if (RST_CYCLES < 1 || TIMEOUT < 2 || LFSR_SEED == '0) begin : g_param_check
        $error("aes_kat_sequencer: invalid parameter value");
    end

    state_t       state, state_next;
    logic [31:0]  cnt;
    logic [7:0]   idx;
    logic [127:0] result;
    logic [127:0] expected;
    logic         checked;
    logic         timed_out;
    logic         got_done;
    logic         last_test;
    logic         test_failed;

    logic [7:0]   ld_idx;
    logic         ld_mode;
    logic [127:0] ld_data;
    logic [127:0] ld_key;
    logic [127:0] ld_exp;
    logic         ld_chk;

`ifdef AES_KAT_ROUNDTRIP_EN
    // Galois LFSR, taps 128,127,126,121 (bits 127,126,125,120 of the mask).
    localparam logic [127:0] LFSR_MASK = 128'he1000000000000000000000000000000;
    logic [127:0] lfsr;
`endif

    // The first RUN cycle ignores aes_done, because the core may still show a stale level.
    assign got_done    = (cnt != 32'd0) && aes_done;
    assign last_test   = ({24'd0, idx} == N_TESTS - 1);
    assign test_failed = timed_out || (checked && (result != expected));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        aes_reset  = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        fail       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                busy = 1'b1;
                if (cnt == RST_CYCLES - 1) state_next = S_RUN;
            end
            S_RUN: begin
                busy      = 1'b1;
                aes_reset = 1'b0;
                if (got_done || cnt == TIMEOUT - 1) state_next = S_CHECK;
            end
            S_CHECK: begin
                busy       = 1'b1;
                state_next = last_test ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done = 1'b1;
                pass = (err_count == 8'd0);
                fail = (err_count != 8'd0);
                if (start) state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Entry for the test about to be loaded: idx+1 from CHECK, 0 on a fresh start.
    always_comb begin
        ld_idx  = (state == S_CHECK) ? idx + 8'd1 : 8'd0;
        ld_mode = 1'b0;
        ld_data = '0;
        ld_key  = '0;
        ld_exp  = '0;
        ld_chk  = 1'b1;
        case (ld_idx)
            8'd0: begin ld_mode = 1'b0; ld_data = PT_A; ld_key = KEY_A; ld_exp = CT_A; end
            8'd1: begin ld_mode = 1'b1; ld_data = CT_A; ld_key = KEY_A; ld_exp = PT_A; end
            8'd2: begin ld_mode = 1'b0; ld_data = PT_B; ld_key = KEY_B; ld_exp = CT_B; end
            8'd3: begin ld_mode = 1'b1; ld_data = CT_B; ld_key = KEY_B; ld_exp = PT_B; end
            default: begin
`ifdef AES_KAT_ROUNDTRIP_EN
                // Even index encrypts the LFSR word (unchecked), odd index
                // decrypts the captured ciphertext back to that word.
                ld_key  = KEY_A;
                ld_mode = ld_idx[0];
                if (ld_idx[0]) begin
                    ld_data = result;
                    ld_exp  = lfsr;
                end else begin
                    ld_data = lfsr;
                    ld_chk  = 1'b0;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            aes_mode    <= 1'b0;
            aes_data_in <= '0;
            aes_key_in  <= '0;
            result      <= '0;
            expected    <= '0;
            checked     <= 1'b0;
            timed_out   <= 1'b0;
            err_count   <= '0;
            first_fail  <= '1;
        end else begin
            if (state_next == state && (state == S_LOAD || state == S_RUN))
                cnt <= cnt + 32'd1;
            else
                cnt <= '0;

            if (state_next == S_LOAD && state != S_LOAD) begin
                idx         <= ld_idx;
                aes_mode    <= ld_mode;
                aes_data_in <= ld_data;
                aes_key_in  <= ld_key;
                expected    <= ld_exp;
                checked     <= ld_chk;
            end

            if ((state == S_IDLE || state == S_DONE) && start) begin
                err_count  <= '0;
                first_fail <= '1;
            end

            if (state == S_RUN && state_next == S_CHECK) begin
                timed_out <= !got_done;
                if (got_done) result <= aes_data_out;
            end

            if (state == S_CHECK && test_failed) begin
                if (err_count != 8'hFF)   err_count  <= err_count + 8'd1;
                if (first_fail == 8'hFF)  first_fail <= idx;
            end
        end
    end

`ifdef AES_KAT_ROUNDTRIP_EN
    // Advanced when an encrypt half is checked. The decrypt half being
    // loaded on that same edge still latches the pre-advance word as its
    // expected value.
    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else if ((state == S_IDLE || state == S_DONE) && start)
            lfsr <= LFSR_SEED;
        else if (state == S_CHECK && idx >= 8'd4 && !idx[0])
            lfsr <= {1'b0, lfsr[127:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
    end
`endif

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Self-checking bench for aes_kat_sequencer (default build: 4 fixed tests).
// A behavioural stub stands in for the AES core. It has a programmable
// latency and can corrupt one test's result or never raise done.
module tb_aes_kat_sequencer;

    localparam int unsigned RST = 4;
    localparam int unsigned TMO = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         aes_reset;
    logic         aes_mode;
    logic [127:0] aes_data_in;
    logic [127:0] aes_key_in;
    logic [127:0] aes_data_out;
    logic         aes_done;
    logic         busy, done, pass, fail;
    logic [7:0]   err_count, first_fail;

    aes_kat_sequencer #(.RST_CYCLES(RST), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .aes_reset(aes_reset), .aes_mode(aes_mode),
        .aes_data_in(aes_data_in), .aes_key_in(aes_key_in),
        .aes_data_out(aes_data_out), .aes_done(aes_done),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .err_count(err_count), .first_fail(first_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         mode;
        logic [127:0] data;
        logic [127:0] key;
        logic [127:0] exp;
    } kat_t;

    function automatic kat_t kat(input int i);
        kat_t k;
        case (i)
            0: k = '{1'b0, 128'h3243f6a8885a308d313198a2e0370734,
                     128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32};
            1: k = '{1'b1, 128'h3925841d02dc09fbdc118597196a0b32,
                     128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734};
            2: k = '{1'b0, 128'h00112233445566778899aabbccddeeff,
                     128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
            default: k = '{1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                     128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff};
        endcase
        return k;
    endfunction

    // ---------------- stub core ----------------
    int   stub_lat = 3;
    int   stub_bad = -1;
    bit   stub_hang = 1'b0;
    logic [7:0] sc;

    always @(posedge clk) begin
        if (aes_reset) sc <= 8'd0;
        else if (sc != stub_lat[7:0]) sc <= sc + 8'd1;
    end

    function automatic logic [127:0] stub_out(input logic m, input logic [127:0] d,
                                               input logic [127:0] key, input int bad);
        kat_t k;
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            k = kat(i);
            if (k.mode === m && k.data === d && k.key === key)
                r = k.exp ^ ((i == bad) ? 128'd1 : 128'd0);
        end
        return r;
    endfunction

    assign aes_done     = !stub_hang && (sc == stub_lat[7:0]);
    assign aes_data_out = stub_out(aes_mode, aes_data_in, aes_key_in, stub_bad);

    // ---------------- checking ----------------
    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of core-input sets expected at each RUN entry.
    kat_t sbq[$];
    int   runs_seen = 0;
    logic prev_rst = 1'b1;

    always @(negedge clk) begin
        kat_t e;
        if (prev_rst === 1'b1 && aes_reset === 1'b0) begin
            runs_seen++;
            if (sbq.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL sb_underflow: got run with data %h expected none", aes_data_in);
            end else begin
                e = sbq.pop_front();
                chk("sb_mode", {127'd0, aes_mode}, {127'd0, e.mode});
                chk("sb_data", aes_data_in, e.data);
                chk("sb_key",  aes_key_in,  e.key);
            end
        end
        prev_rst = aes_reset;
    end

    typedef struct {
        int         lat;
        int         bad;
        bit         hang;
        bit         poke;
        logic [7:0] err;
        logic [7:0] ff;
        int         cycles;
    } scen_t;

    task automatic run_scen(input scen_t s, input string tag);
        int n;
        stub_lat  = s.lat;
        stub_bad  = s.bad;
        stub_hang = s.hang;
        for (int i = 0; i < 4; i++) sbq.push_back(kat(i));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, ".busy_at_start"}, {127'd0, busy}, 128'd1);
        chk({tag, ".done_cleared"},  {127'd0, done}, 128'd0);
        chk({tag, ".err_cleared"},   {120'd0, err_count}, 128'd0);
        chk({tag, ".ff_cleared"},    {120'd0, first_fail}, 128'hFF);
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
            start = s.poke && (n == 2 || n == 6 || n == 12);
        end
        start = 1'b0;
        chk({tag, ".cycles"}, 128'(n), 128'(s.cycles));
        chk({tag, ".done"},   {127'd0, done}, 128'd1);
        chk({tag, ".pass"},   {127'd0, pass}, {127'd0, (s.err == 8'd0)});
        chk({tag, ".fail"},   {127'd0, fail}, {127'd0, (s.err != 8'd0)});
        chk({tag, ".err"},    {120'd0, err_count}, {120'd0, s.err});
        chk({tag, ".ff"},     {120'd0, first_fail}, {120'd0, s.ff});
        chk({tag, ".busy_end"}, {127'd0, busy}, 128'd0);
        chk({tag, ".sb_empty"}, 128'(sbq.size()), 128'd0);
    endtask

    scen_t tbl[6];

    initial begin
        int base, n;
        // lat, bad idx, hang, poke start, exp err, exp first_fail, exp cycles
        tbl[0] = '{3, -1, 1'b0, 1'b0, 8'd0, 8'hFF, 36};
        tbl[1] = '{3,  1, 1'b0, 1'b0, 8'd1, 8'd1,  36};
        tbl[2] = '{3, -1, 1'b1, 1'b0, 8'd4, 8'd0,  84};
        tbl[3] = '{0,  3, 1'b0, 1'b0, 8'd1, 8'd3,  28};
        tbl[4] = '{5, -1, 1'b0, 1'b1, 8'd0, 8'hFF, 44};
        tbl[5] = '{2,  0, 1'b0, 1'b0, 8'd1, 8'd0,  32};

        repeat (3) @(negedge clk);
        chk("rst.aes_reset", {127'd0, aes_reset}, 128'd1);
        chk("rst.mode",      {127'd0, aes_mode}, 128'd0);
        chk("rst.data",      aes_data_in, 128'd0);
        chk("rst.key",       aes_key_in, 128'd0);
        chk("rst.flags",     {124'd0, busy, done, pass, fail}, 128'd0);
        chk("rst.err",       {120'd0, err_count}, 128'd0);
        chk("rst.ff",        {120'd0, first_fail}, 128'hFF);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle.busy", {127'd0, busy}, 128'd0);

        for (int i = 0; i < 6; i++) run_scen(tbl[i], $sformatf("s%0d", i));

        // Reset in the middle of test 2's RUN, after test 1 has already failed.
        stub_lat = 3; stub_bad = 1; stub_hang = 1'b0;
        for (int i = 0; i < 4; i++) sbq.push_back(kat(i));
        base = runs_seen;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (runs_seen < base + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4.reached_idx2", 128'(runs_seen - base), 128'd3);
        chk("t4.in_run",       {127'd0, aes_reset}, 128'd0);
        chk("t4.err_before",   {120'd0, err_count}, 128'd1);
        chk("t4.ff_before",    {120'd0, first_fail}, 128'd1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("t4.aes_reset", {127'd0, aes_reset}, 128'd1);
        chk("t4.busy",      {127'd0, busy}, 128'd0);
        chk("t4.done",      {127'd0, done}, 128'd0);
        chk("t4.err",       {120'd0, err_count}, 128'd0);
        chk("t4.ff",        {120'd0, first_fail}, 128'hFF);
        chk("t4.data",      aes_data_in, 128'd0);
        chk("t4.key",       aes_key_in, 128'd0);
        chk("t4.sb_left",   128'(sbq.size()), 128'd1);
        sbq.delete();
        repeat (3) @(negedge clk);
        chk("t4.still_idle", {127'd0, busy}, 128'd0);
        run_scen(tbl[0], "t4_rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
